// File: rtl/ifmap_radr_gen_ext_if.sv
`default_nettype none
// ============================================================================
//  Module   : ifmap_radr_gen_ext_if
//  Purpose  : Controller <-> ifmap read-address generator bundle (config,
//             request, address/pad/valid/done response).
//  Revision : 1.0  initial release
// ============================================================================
interface ifmap_radr_gen_ext_if #(
   parameter int BANK_ADDR_WIDTH = 8,
   parameter int NUM_FIELDS      = 11
);
   logic                                  config_en;
   logic [NUM_FIELDS*BANK_ADDR_WIDTH-1:0] config_data;
   logic                                  adr_en;
   logic [BANK_ADDR_WIDTH-1:0]            adr;
   logic                                  adr_vld;
   logic                                  pad;
   logic                                  done;

   modport master (
      output config_en, config_data, adr_en,
      input  adr, adr_vld, pad, done
   );

   modport slave (
      input  config_en, config_data, adr_en,
      output adr, adr_vld, pad, done
   );
endinterface
`default_nettype wire

// File: rtl/ifmap_radr_gen_ext.sv
`default_nettype none
// ============================================================================
//  Module   : ifmap_radr_gen_ext
//  Purpose  : Walks the tiled-convolution loop nest (with dilation, padding
//             and OC1 repeat) issuing one ifmap buffer address per adr_en.
//  Revision : 1.0  initial release
// ============================================================================
module ifmap_radr_gen_ext #(
   parameter int BANK_ADDR_WIDTH = 8,
   parameter int NUM_FIELDS      = 11
) (
   input  logic                clk,
   input  logic                rst_n,
   ifmap_radr_gen_ext_if.slave bus
);
   localparam int W     = BANK_ADDR_WIDTH;
   localparam int CW    = 2*W + 1;
   localparam int CFG_W = NUM_FIELDS*W;

   function automatic logic [W-1:0] eff(input logic [W-1:0] v);
      return (v == '0) ? W'(1) : v;
   endfunction

   logic [CFG_W-1:0] cfg_q, cfg_d;
   logic [W-1:0]     ox0_q, ox0_d, oy0_q, oy0_d, fx_q, fx_d;
   logic [W-1:0]     fy_q, fy_d, ic1_q, ic1_d, oc1_q, oc1_d;
   logic [W-1:0]     adr_q, adr_d;
   logic             adr_vld_q, adr_vld_d, pad_q, pad_d, done_q, done_d;

   logic [W-1:0] ox0_f, oy0_f, fx_f, fy_f, stride_f, ix0_f, iy0_f;
   logic [W-1:0] ic1_f, oc1_f, dil_f, pad_f;

   assign ox0_f    = cfg_q[10*W +: W];
   assign oy0_f    = cfg_q[ 9*W +: W];
   assign fx_f     = cfg_q[ 8*W +: W];
   assign fy_f     = cfg_q[ 7*W +: W];
   assign stride_f = cfg_q[ 6*W +: W];
   assign ix0_f    = cfg_q[ 5*W +: W];
   assign iy0_f    = cfg_q[ 4*W +: W];
   assign ic1_f    = cfg_q[ 3*W +: W];
   assign oc1_f    = cfg_q[ 2*W +: W];
   assign dil_f    = cfg_q[ 1*W +: W];
   assign pad_f    = cfg_q[ 0*W +: W];

   // Cumulative carries: each level wraps only when all inner levels wrap too.
   logic c_ox, c_oy, c_fx, c_fy, c_ic, c_oc;
   assign c_ox = (ox0_q == eff(ox0_f) - W'(1));
   assign c_oy = c_ox & (oy0_q == eff(oy0_f) - W'(1));
   assign c_fx = c_oy & (fx_q  == eff(fx_f)  - W'(1));
   assign c_fy = c_fx & (fy_q  == eff(fy_f)  - W'(1));
   assign c_ic = c_fy & (ic1_q == eff(ic1_f) - W'(1));
   assign c_oc = c_ic & (oc1_q == eff(oc1_f) - W'(1));

   logic signed [CW-1:0] ix, iy;
   logic                 pad_c;
   logic [W-1:0]         adr_c;

   assign ix = CW'(ox0_q) * CW'(eff(stride_f)) + CW'(fx_q) * CW'(eff(dil_f)) - CW'(pad_f);
   assign iy = CW'(oy0_q) * CW'(eff(stride_f)) + CW'(fy_q) * CW'(eff(dil_f)) - CW'(pad_f);

   assign pad_c = ix[CW-1] | iy[CW-1]
                | (ix >= $signed(CW'(ix0_f)))
                | (iy >= $signed(CW'(iy0_f)));
   // Linear address wraps modulo 2^W by construction of the W-bit arithmetic.
   assign adr_c = (ic1_q * iy0_f + iy[W-1:0]) * ix0_f + ix[W-1:0];

   always_comb begin
      cfg_d     = cfg_q;
      ox0_d     = ox0_q;
      oy0_d     = oy0_q;
      fx_d      = fx_q;
      fy_d      = fy_q;
      ic1_d     = ic1_q;
      oc1_d     = oc1_q;
      adr_d     = adr_q;
      pad_d     = pad_q;
      adr_vld_d = 1'b0;
      done_d    = 1'b0;
      if (bus.config_en) begin
         cfg_d = bus.config_data;
         ox0_d = '0;
         oy0_d = '0;
         fx_d  = '0;
         fy_d  = '0;
         ic1_d = '0;
         oc1_d = '0;
      end else if (bus.adr_en) begin
         adr_vld_d = 1'b1;
         pad_d     = pad_c;
         adr_d     = pad_c ? '0 : adr_c;
         done_d    = c_oc;
         ox0_d     = c_ox ? '0 : ox0_q + W'(1);
         if (c_ox) oy0_d = c_oy ? '0 : oy0_q + W'(1);
         if (c_oy) fx_d  = c_fx ? '0 : fx_q  + W'(1);
         if (c_fx) fy_d  = c_fy ? '0 : fy_q  + W'(1);
         if (c_fy) ic1_d = c_ic ? '0 : ic1_q + W'(1);
         if (c_ic) oc1_d = c_oc ? '0 : oc1_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cfg_q     <= '0;
         ox0_q     <= '0;
         oy0_q     <= '0;
         fx_q      <= '0;
         fy_q      <= '0;
         ic1_q     <= '0;
         oc1_q     <= '0;
         adr_q     <= '0;
         pad_q     <= 1'b0;
         adr_vld_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         cfg_q     <= cfg_d;
         ox0_q     <= ox0_d;
         oy0_q     <= oy0_d;
         fx_q      <= fx_d;
         fy_q      <= fy_d;
         ic1_q     <= ic1_d;
         oc1_q     <= oc1_d;
         adr_q     <= adr_d;
         pad_q     <= pad_d;
         adr_vld_q <= adr_vld_d;
         done_q    <= done_d;
      end
   end

   assign bus.adr     = adr_q;
   assign bus.pad     = pad_q;
   assign bus.adr_vld = adr_vld_q;
   assign bus.done    = done_q;
endmodule
`default_nettype wire

// File: tb/tb_ifmap_radr_gen_ext.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_ifmap_radr_gen_ext
//  Purpose  : Self-checking bench for ifmap_radr_gen_ext against a loop-nest
//             reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ifmap_radr_gen_ext;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   ifmap_radr_gen_ext_if #(.BANK_ADDR_WIDTH(W), .NUM_FIELDS(11)) bus ();

   ifmap_radr_gen_ext #(.BANK_ADDR_WIDTH(W), .NUM_FIELDS(11)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_vec = 0;
   int n_err = 0;
   int f [11];          // OX0,OY0,FX,FY,STRIDE,IX0,IY0,IC1,OC1,DIL,PAD
   int exp_adr [$];
   int exp_pad [$];
   int idx;
   int held_adr;
   int held_pad;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
      end
   endtask

   function automatic int eff(input int v);
      return (v == 0) ? 1 : v;
   endfunction

   // Enumerate the full nest as a flat list of expected beats.
   function automatic void build();
      int ox = eff(f[0]), oy = eff(f[1]), fxn = eff(f[2]), fyn = eff(f[3]);
      int st = eff(f[4]), ix0 = f[5], iy0 = f[6], ic = eff(f[7]), oc = eff(f[8]);
      int dl = eff(f[9]), pd = f[10];
      exp_adr.delete();
      exp_pad.delete();
      for (int c = 0; c < oc; c++)
         for (int k = 0; k < ic; k++)
            for (int b = 0; b < fyn; b++)
               for (int a = 0; a < fxn; a++)
                  for (int y = 0; y < oy; y++)
                     for (int x = 0; x < ox; x++) begin
                        int ix, iy, p;
                        ix = x*st + a*dl - pd;
                        iy = y*st + b*dl - pd;
                        p  = (ix < 0 || ix >= ix0 || iy < 0 || iy >= iy0) ? 1 : 0;
                        exp_pad.push_back(p);
                        exp_adr.push_back(p ? 0 : ((k*iy0 + iy)*ix0 + ix) % 256);
                     end
   endfunction

   function automatic logic [11*W-1:0] packcfg();
      logic [11*W-1:0] d;
      d = '0;
      for (int i = 0; i < 11; i++) d[(10-i)*W +: W] = W'(f[i]);
      return d;
   endfunction

   task automatic setcfg(input int a0, a1, a2, a3, a4, a5, a6, a7, a8, a9, a10);
      f[0] = a0; f[1] = a1; f[2] = a2; f[3] = a3; f[4] = a4; f[5] = a5;
      f[6] = a6; f[7] = a7; f[8] = a8; f[9] = a9; f[10] = a10;
   endtask

   task automatic configure(input bit with_en);
      bus.config_data = packcfg();
      bus.config_en   = 1'b1;
      bus.adr_en      = with_en;
      @(posedge clk); #1;
      bus.config_en = 1'b0;
      bus.adr_en    = 1'b0;
      chk("cfg_vld", bus.adr_vld, 0);
      chk("cfg_done", bus.done, 0);
      build();
      idx = 0;
   endtask

   task automatic beat(input bit en);
      bus.adr_en = en;
      @(posedge clk); #1;
      bus.adr_en = 1'b0;
      if (en) begin
         chk("vld", bus.adr_vld, 1);
         chk("adr", bus.adr, exp_adr[idx]);
         chk("pad", bus.pad, exp_pad[idx]);
         chk("done", bus.done, (idx == exp_adr.size() - 1) ? 1 : 0);
         held_adr = exp_adr[idx];
         held_pad = exp_pad[idx];
         idx = (idx + 1) % exp_adr.size();
      end else begin
         chk("idle_vld", bus.adr_vld, 0);
         chk("idle_adr", bus.adr, held_adr);
         chk("idle_pad", bus.pad, held_pad);
         chk("idle_done", bus.done, 0);
      end
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      bus.adr_en = 1'b1;
      @(posedge clk); #1;
      bus.adr_en = 1'b0;
      chk("rst_adr", bus.adr, 0);
      chk("rst_vld", bus.adr_vld, 0);
      chk("rst_pad", bus.pad, 0);
      chk("rst_done", bus.done, 0);
      rst_n    = 1'b1;
      held_adr = 0;
      held_pad = 0;
   endtask

   initial begin
      bus.config_en   = 1'b0;
      bus.config_data = '0;
      bus.adr_en      = 1'b0;
      rst_n           = 1'b0;
      @(posedge clk); #1;
      do_reset();

      // Basic 2x2 over 3x3, plus wrap into the next nest
      setcfg(2, 2, 2, 2, 1, 3, 3, 1, 1, 1, 0);
      configure(0);
      for (int i = 0; i < 18; i++) beat(1);

      // Flow control, entered via config+adr_en collision
      configure(1);
      for (int i = 0; i < 32; i++) beat((i % 4 == 0) || (i % 4 == 3));

      // Stride/dilation
      setcfg(2, 1, 2, 1, 2, 8, 1, 1, 1, 2, 0);
      configure(0);
      for (int i = 0; i < 5; i++) beat(1);

      // Padding
      setcfg(3, 3, 3, 3, 1, 3, 3, 1, 1, 1, 1);
      configure(0);
      for (int i = 0; i < 82; i++) beat(1);

      // Channels and OC1 repeat
      setcfg(2, 2, 1, 1, 1, 2, 2, 2, 2, 1, 0);
      configure(0);
      for (int i = 0; i < 17; i++) beat(1);

      // Reset and reconfig mid-nest
      setcfg(2, 2, 2, 2, 1, 3, 3, 1, 1, 1, 0);
      configure(0);
      for (int i = 0; i < 5; i++) beat(1);
      do_reset();
      configure(0);
      for (int i = 0; i < 5; i++) beat(1);
      configure(1);
      for (int i = 0; i < 4; i++) beat(1);

      // Randomised configurations, zero-programmed counts included
      for (int n = 0; n < 12; n++) begin
         setcfg($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 10),
                $urandom_range(0, 10), $urandom_range(0, 3), $urandom_range(0, 2),
                $urandom_range(0, 3), $urandom_range(0, 3));
         configure($urandom_range(0, 1));
         for (int i = 0; i < exp_adr.size() + 3; i++) beat(($urandom % 4) != 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
